regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 135 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : 4-read / 2-alloc / 2-write-back register file with busy scoreboard
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int OPRAND_WIDTH  = 32,
  parameter int REGNAME_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd11_en,
  input  logic [REGNAME_WIDTH-1:0] rd11_addr,
  input  logic                     rd12_en,
  input  logic [REGNAME_WIDTH-1:0] rd12_addr,
  input  logic                     rd21_en,
  input  logic [REGNAME_WIDTH-1:0] rd21_addr,
  input  logic                     rd22_en,
  input  logic [REGNAME_WIDTH-1:0] rd22_addr,
  output logic                     read11_ready,
  output logic                     read11_valid_bit,
  output logic [OPRAND_WIDTH-1:0]  read11_data,
  output logic                     read12_ready,
  output logic                     read12_valid_bit,
  output logic [OPRAND_WIDTH-1:0]  read12_data,
  output logic                     read21_ready,
  output logic                     read21_valid_bit,
  output logic [OPRAND_WIDTH-1:0]  read21_data,
  output logic                     read22_ready,
  output logic                     read22_valid_bit,
  output logic [OPRAND_WIDTH-1:0]  read22_data,
  input  logic                     alloc_en1,
  input  logic [REGNAME_WIDTH-1:0] alloc_target1,
  input  logic                     alloc_en2,
  input  logic [REGNAME_WIDTH-1:0] alloc_target2,
  input  logic                     WB_en1,
  input  logic [REGNAME_WIDTH-1:0] WB_target1,
  input  logic [OPRAND_WIDTH-1:0]  WB_data1,
  input  logic                     WB_en2,
  input  logic [REGNAME_WIDTH-1:0] WB_target2,
  input  logic [OPRAND_WIDTH-1:0]  WB_data2,
  input  logic                     flush
);

  localparam int NUM_REGS = 2 ** REGNAME_WIDTH;
  localparam int NUM_RD   = 4;

  logic [OPRAND_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;

  logic [NUM_RD-1:0]        rd_en;
  logic [REGNAME_WIDTH-1:0] rd_addr [NUM_RD];
  logic [NUM_RD-1:0]        rsp_ready_q;
  logic [NUM_RD-1:0]        rsp_valid_d, rsp_valid_q;
  logic [OPRAND_WIDTH-1:0]  rsp_data_d [NUM_RD];
  logic [OPRAND_WIDTH-1:0]  rsp_data_q [NUM_RD];

  logic wb1_live, wb2_live;

  assign wb1_live = WB_en1 && (WB_target1 != '0);
  assign wb2_live = WB_en2 && (WB_target2 != '0);

  assign rd_en      = {rd22_en, rd21_en, rd12_en, rd11_en};
  assign rd_addr[0] = rd11_addr;
  assign rd_addr[1] = rd12_addr;
  assign rd_addr[2] = rd21_addr;
  assign rd_addr[3] = rd22_addr;

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic hit1, hit2, dep, is_zero;
      assign hit1    = WB_en1 && (WB_target1 == rd_addr[p]);
      assign hit2    = WB_en2 && (WB_target2 == rd_addr[p]);
      assign is_zero = (rd_addr[p] == '0);
      // Slot-2 operands see the slot-1 destination dispatched alongside them.
      if (p >= 2) begin : g_dep
        assign dep = alloc_en1 && (alloc_target1 == rd_addr[p]);
      end else begin : g_nodep
        assign dep = 1'b0;
      end
      assign rsp_valid_d[p] = rd_en[p] &&
                              (is_zero || (!dep && (!busy_q[rd_addr[p]] || hit1 || hit2)));
      assign rsp_data_d[p]  = (!rd_en[p] || is_zero) ? '0 :
                              hit2 ? WB_data2 :
                              hit1 ? WB_data1 : regs_q[rd_addr[p]];
    end
  endgenerate

  // Allocs are applied after write-back clears so a same-cycle alloc keeps busy set.
  always_comb begin
    busy_d = busy_q;
    if (wb1_live) busy_d[WB_target1] = 1'b0;
    if (wb2_live) busy_d[WB_target2] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (alloc_en1) busy_d[alloc_target1] = 1'b1;
      if (alloc_en2) busy_d[alloc_target2] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q      <= '0;
      rsp_ready_q <= '0;
      rsp_valid_q <= '0;
      for (int p = 0; p < NUM_RD; p++) rsp_data_q[p] <= '0;
    end else begin
      if (wb1_live) regs_q[WB_target1] <= WB_data1;
      if (wb2_live) regs_q[WB_target2] <= WB_data2;
      busy_q      <= busy_d;
      rsp_ready_q <= rd_en;
      rsp_valid_q <= rsp_valid_d;
      for (int p = 0; p < NUM_RD; p++) rsp_data_q[p] <= rsp_data_d[p];
    end
  end

  assign read11_ready     = rsp_ready_q[0];
  assign read11_valid_bit = rsp_valid_q[0];
  assign read11_data      = rsp_data_q[0];
  assign read12_ready     = rsp_ready_q[1];
  assign read12_valid_bit = rsp_valid_q[1];
  assign read12_data      = rsp_data_q[1];
  assign read21_ready     = rsp_ready_q[2];
  assign read21_valid_bit = rsp_valid_q[2];
  assign read21_data      = rsp_data_q[2];
  assign read22_ready     = rsp_ready_q[3];
  assign read22_valid_bit = rsp_valid_q[3];
  assign read22_data      = rsp_data_q[3];

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed + random bench for regfile_scoreboard with reference model
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;
  localparam int OW = 32;
  localparam int RW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rd_en   [4];
  logic [RW-1:0] rd_addr [4];
  logic          a_en1, a_en2, w_en1, w_en2, flush;
  logic [RW-1:0] a_t1, a_t2, w_t1, w_t2;
  logic [OW-1:0] w_d1, w_d2;
  logic [3:0]    rdy, vb;
  logic [OW-1:0] dat0, dat1, dat2, dat3;

  regfile_scoreboard #(.OPRAND_WIDTH(OW), .REGNAME_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .rd11_en(rd_en[0]), .rd11_addr(rd_addr[0]),
    .rd12_en(rd_en[1]), .rd12_addr(rd_addr[1]),
    .rd21_en(rd_en[2]), .rd21_addr(rd_addr[2]),
    .rd22_en(rd_en[3]), .rd22_addr(rd_addr[3]),
    .read11_ready(rdy[0]), .read11_valid_bit(vb[0]), .read11_data(dat0),
    .read12_ready(rdy[1]), .read12_valid_bit(vb[1]), .read12_data(dat1),
    .read21_ready(rdy[2]), .read21_valid_bit(vb[2]), .read21_data(dat2),
    .read22_ready(rdy[3]), .read22_valid_bit(vb[3]), .read22_data(dat3),
    .alloc_en1(a_en1), .alloc_target1(a_t1),
    .alloc_en2(a_en2), .alloc_target2(a_t2),
    .WB_en1(w_en1), .WB_target1(w_t1), .WB_data1(w_d1),
    .WB_en2(w_en2), .WB_target2(w_t2), .WB_data2(w_d2),
    .flush(flush)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural model: committed values and outstanding-producer flags.
  logic [OW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic          e_rdy  [4];
  logic          e_vb   [4];
  logic [OW-1:0] e_dat  [4];

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      rd_en[p]   = 1'b0;
      rd_addr[p] = '0;
    end
    a_en1 = 0; a_en2 = 0; w_en1 = 0; w_en2 = 0; flush = 0;
    a_t1 = '0; a_t2 = '0; w_t1 = '0; w_t2 = '0; w_d1 = '0; w_d2 = '0;
  endtask

  task automatic expect_reads();
    for (int p = 0; p < 4; p++) begin
      int a;
      a = int'(rd_addr[p]);
      e_rdy[p] = 1'b0; e_vb[p] = 1'b0; e_dat[p] = '0;
      if (!rst && rd_en[p]) begin
        e_rdy[p] = 1'b1;
        if (a == 0) begin
          e_vb[p] = 1'b1;
        end else begin
          bit written;
          written  = (w_en1 && int'(w_t1) == a) || (w_en2 && int'(w_t2) == a);
          e_dat[p] = (w_en2 && int'(w_t2) == a) ? w_d2 :
                     (w_en1 && int'(w_t1) == a) ? w_d1 : m_regs[a];
          e_vb[p]  = (!m_busy[a] || written) &&
                     !(p >= 2 && a_en1 && int'(a_t1) == a);
        end
      end
    end
  endtask

  task automatic update_model();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w_en1) begin m_regs[w_t1] = w_d1; m_busy[w_t1] = 1'b0; end
      if (w_en2) begin m_regs[w_t2] = w_d2; m_busy[w_t2] = 1'b0; end
      if (flush) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
        if (a_en1) m_busy[a_t1] = 1'b1;
        if (a_en2) m_busy[a_t2] = 1'b1;
      end
      m_regs[0] = '0;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic step();
    logic [OW-1:0] d [4];
    expect_reads();
    @(posedge clk);
    update_model();
    #1;
    d[0] = dat0; d[1] = dat1; d[2] = dat2; d[3] = dat3;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("ready[%0d]", p), {31'd0, rdy[p]}, {31'd0, e_rdy[p]});
      chk($sformatf("valid[%0d]", p), {31'd0, vb[p]}, {31'd0, e_vb[p]});
      chk($sformatf("data[%0d]", p), d[p], e_dat[p]);
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < NR; i++) begin m_regs[i] = 'x; m_busy[i] = 1'bx; end
    rst = 1'b1;
    rd_en[0] = 1; rd_addr[0] = 5; w_en1 = 1; w_t1 = 5; w_d1 = 32'h1234; a_en1 = 1; a_t1 = 6;
    step();
    idle();
    step();
    chk("reset_ready", {31'd0, rdy[0]}, 32'd0);
    rst = 1'b0;

    rd_en[0] = 1; rd_addr[0] = 5;
    step();
    chk("r24_ready", {31'd0, rdy[0]}, 32'd1);
    chk("r24_valid", {31'd0, vb[0]}, 32'd1);
    chk("r24_data", dat0, 32'd0);

    idle(); a_en1 = 1; a_t1 = 7; step();
    idle(); rd_en[0] = 1; rd_addr[0] = 7; step();
    chk("r25_pending", {31'd0, vb[0]}, 32'd0);
    idle(); w_en1 = 1; w_t1 = 7; w_d1 = 32'hDEAD_BEEF; rd_en[1] = 1; rd_addr[1] = 7; step();
    chk("r25_bypass_valid", {31'd0, vb[1]}, 32'd1);
    chk("r25_bypass_data", dat1, 32'hDEAD_BEEF);

    idle(); w_en1 = 1; w_t1 = 3; w_d1 = 32'h11; w_en2 = 1; w_t2 = 3; w_d2 = 32'h22;
    rd_en[2] = 1; rd_addr[2] = 3; step();
    chk("r26_same_cycle", dat2, 32'h22);
    idle(); rd_en[0] = 1; rd_addr[0] = 3; step();
    chk("r26_later", dat0, 32'h22);

    idle(); a_en1 = 1; a_t1 = 9; rd_en[2] = 1; rd_addr[2] = 9; rd_en[0] = 1; rd_addr[0] = 9; step();
    chk("r27_slot2_dep", {31'd0, vb[2]}, 32'd0);
    chk("r27_slot1_nodep", {31'd0, vb[0]}, 32'd1);

    idle(); a_en1 = 1; a_t1 = 4; a_en2 = 1; a_t2 = 6; step();
    idle(); flush = 1; a_en1 = 1; a_t1 = 12; step();
    idle(); rd_en[0] = 1; rd_addr[0] = 4; rd_en[1] = 1; rd_addr[1] = 6; rd_en[3] = 1; rd_addr[3] = 12; step();
    chk("r28_flush4", {31'd0, vb[0]}, 32'd1);
    chk("r28_flush6", {31'd0, vb[1]}, 32'd1);
    chk("r28_flush_alloc_ignored", {31'd0, vb[3]}, 32'd1);
    idle(); w_en1 = 1; w_t1 = 0; w_d1 = 32'hFF; rd_en[1] = 1; rd_addr[1] = 0; step();
    chk("r28_zero_bypass", dat1, 32'd0);
    idle(); rd_en[0] = 1; rd_addr[0] = 0; step();
    chk("r28_zero_data", dat0, 32'd0);
    chk("r28_zero_valid", {31'd0, vb[0]}, 32'd1);

    idle(); a_en2 = 1; a_t2 = 10; w_en1 = 1; w_t1 = 10; w_d1 = 32'hABC; step();
    idle(); rd_en[0] = 1; rd_addr[0] = 10; step();
    chk("r29_data", dat0, 32'hABC);
    chk("r29_still_busy", {31'd0, vb[0]}, 32'd0);

    // Small address range keeps collisions between reads, allocs and WBs frequent.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 4; p++) begin
        rd_en[p]   = ($urandom_range(0, 3) != 0);
        rd_addr[p] = RW'($urandom_range(0, 7));
      end
      a_en1 = $urandom_range(0, 1) == 1; a_t1 = RW'($urandom_range(0, 7));
      a_en2 = $urandom_range(0, 1) == 1; a_t2 = RW'($urandom_range(0, 7));
      w_en1 = $urandom_range(0, 1) == 1; w_t1 = RW'($urandom_range(0, 7)); w_d1 = $urandom;
      w_en2 = $urandom_range(0, 1) == 1; w_t2 = RW'($urandom_range(0, 7)); w_d2 = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
